// File: rtl/clip_rr_sched_pkg.sv
// Shared constants and types for the clip_rr_sched requantize/saturate scheduler.
// The module parameters of clip_rr_sched default to the widths below.
// The S1 payload struct is sized from these widths, so a width change belongs here.
package clip_rr_sched_pkg;

  localparam int CRS_NUM_REQ = 4;
  localparam int CRS_IN_W    = 21;
  localparam int CRS_OUT_W   = 8;
  localparam int CRS_SHIFT_W = 5;
  localparam int CRS_ID_W    = $clog2(CRS_NUM_REQ);

  // The rounding add and the shift run one bit wider than the input, so the add cannot overflow.
  localparam int CRS_EXT_W = CRS_IN_W + 1;

  // Saturation bounds, held at the extended width for the signed compare.
  localparam logic signed [CRS_EXT_W-1:0] CRS_SAT_MAX = CRS_EXT_W'((1 << (CRS_OUT_W-1)) - 1);
  localparam logic signed [CRS_EXT_W-1:0] CRS_SAT_MIN = CRS_EXT_W'(-(1 << (CRS_OUT_W-1)));

  // Clipped output codes.
  localparam logic [CRS_OUT_W-1:0] CRS_OUT_MAX = {1'b0, {(CRS_OUT_W-1){1'b1}}};
  localparam logic [CRS_OUT_W-1:0] CRS_OUT_MIN = {1'b1, {(CRS_OUT_W-1){1'b0}}};

  // Contents of the first pipeline stage: the raw accumulator, its source and the shift amount.
  typedef struct packed {
    logic signed [CRS_IN_W-1:0] data;
    logic [CRS_ID_W-1:0]        id;
    logic [CRS_SHIFT_W-1:0]     shift;
  } s1_payload_t;

endpackage

// File: rtl/clip_rr_sched_rr_arbiter.sv
// Round-robin arbiter.
// The search starts at the pointer and wraps modulo NUM_REQ.
// The grant is one-hot, and it is issued only while the consumer can take a beat (enable).
// After a grant, the pointer moves to the granted index + 1.
module clip_rr_sched_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic                enable,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                grant_any
);

  logic [ID_WIDTH-1:0] ptr;
  logic                found;
  logic [ID_WIDTH-1:0] pick;

  // Find the first valid requester, starting at the pointer and wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(idx);
      end
    end
  end

  assign grant_any = found & enable;
  assign grant_id  = pick;

  // Decode the chosen index into a one-hot grant.
  always_comb begin
    grant = '0;
    if (grant_any) grant[pick] = 1'b1;
  end

  // Move the pointer past the granted source. It holds when no beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (int'(pick) == NUM_REQ - 1) ptr <= '0;
      else                           ptr <= pick + 1'b1;
    end
  end

endmodule

// File: rtl/clip_rr_sched.sv
// Round-robin scheduler in front of one shared requantize-and-saturate datapath.
// S1 holds the selected raw word. S2 holds the rounded, saturated result that drives out_*.
// Handshakes: a transfer happens on a rising edge where valid && ready.
//   An upstream source holds req_valid and its data until that source is accepted.
//   out_* stay stable while out_valid && !out_ready.
module clip_rr_sched
  import clip_rr_sched_pkg::*;
#(
  parameter int NUM_REQ      = CRS_NUM_REQ,
  parameter int INPUT_WIDTH  = CRS_IN_W,
  parameter int OUTPUT_WIDTH = CRS_OUT_W,
  parameter int SHIFT_WIDTH  = CRS_SHIFT_W,
  parameter int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
  input  logic [SHIFT_WIDTH-1:0]         cfg_shift,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUTPUT_WIDTH-1:0]        out_data,
  output logic [ID_WIDTH-1:0]            out_id
);

  logic                          s1_valid;
  s1_payload_t                   s1_q;
  logic                          s1_load;
  logic                          s2_load;
  logic                          accept;
  logic [ID_WIDTH-1:0]           grant_id;
  logic signed [INPUT_WIDTH-1:0] sel_data;
  logic signed [INPUT_WIDTH:0]   ext;
  logic signed [INPUT_WIDTH:0]   rnd;
  logic signed [INPUT_WIDTH:0]   shifted;
  logic [OUTPUT_WIDTH-1:0]       sat_val;

  // A stage advances when it is empty or when the stage after it moves.
  assign s2_load = !out_valid || out_ready;
  assign s1_load = !s1_valid || s2_load;

  clip_rr_sched_rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .enable    (s1_load),
    .grant     (req_ready),
    .grant_id  (grant_id),
    .grant_any (accept)
  );

  assign sel_data = req_data[int'(grant_id)*INPUT_WIDTH +: INPUT_WIDTH];

  // S1 captures the granted word, its id and the shift in force for this beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_q.data  <= sel_data;
        s1_q.id    <= grant_id;
        s1_q.shift <= cfg_shift;
      end
    end
  end

  // Rounding arithmetic right shift, rounding half toward +inf, followed by a signed clip.
  always_comb begin
    ext     = {s1_q.data[INPUT_WIDTH-1], s1_q.data};
    rnd     = '0;
    shifted = ext;
    if (s1_q.shift == '0) begin
      shifted = ext;
    end else if (int'(s1_q.shift) >= INPUT_WIDTH) begin
      // Shifting out every bit leaves only the sign.
      shifted = s1_q.data[INPUT_WIDTH-1] ? '1 : '0;
    end else begin
      rnd[s1_q.shift - 1'b1] = 1'b1;
      shifted = (ext + rnd) >>> s1_q.shift;
    end
    if (shifted > CRS_SAT_MAX)      sat_val = CRS_OUT_MAX;
    else if (shifted < CRS_SAT_MIN) sat_val = CRS_OUT_MIN;
    else                            sat_val = shifted[OUTPUT_WIDTH-1:0];
  end

  // S2 registers the result, which drives the output stream directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= sat_val;
        out_id   <= s1_q.id;
      end
    end
  end

endmodule

// File: tb/tb_clip_rr_sched.sv
// Directed testbench for clip_rr_sched.
// Each accepted beat pushes its expected {id, data} into a scoreboard queue.
// Results popped from the queue are compared with the DUT output.
module tb_clip_rr_sched;

  localparam int NR  = 4;
  localparam int IW  = 21;
  localparam int OW  = 8;
  localparam int SW  = 5;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*IW-1:0]  req_data;
  logic [SW-1:0]     cfg_shift;
  logic              out_valid;
  logic              out_ready;
  logic [OW-1:0]     out_data;
  logic [IDW-1:0]    out_id;

  logic signed [IW-1:0] src_d [NR];

  logic [IDW+OW-1:0] exp_q[$];
  int                acc_q[$];
  int                n_cmp = 0;
  int                n_fail = 0;
  int                cyc = 0;
  bit                chk_lat = 1'b1;
  bit                granted;
  int                last_grant = 0;
  logic [NR-1:0]     ready_seen;
  logic [OW-1:0]     hold_d;
  logic [IDW-1:0]    hold_id;

  // clock
  always #5 clk = ~clk;

  clip_rr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  // Pack the per-source words onto the flat data bus.
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NR; i++) req_data[i*IW +: IW] = src_d[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: exact integer arithmetic with floor division.
  function automatic logic [OW-1:0] model(input logic signed [IW-1:0] x, input int s);
    longint xv, d, num, q;
    xv = longint'(x);
    if (s == 0) q = xv;
    else if (s >= IW) q = (xv < 0) ? -1 : 0;
    else begin
      d   = longint'(1) << s;
      num = xv + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
    end
    if (q > (longint'(1) << (OW-1)) - 1) return {1'b0, {(OW-1){1'b1}}};
    if (q < -(longint'(1) << (OW-1)))    return {1'b1, {(OW-1){1'b0}}};
    return OW'(q);
  endfunction

  function automatic logic signed [IW-1:0] rnd_word();
    logic signed [IW-1:0] v;
    v = IW'($urandom);
    if ($urandom_range(0, 1) == 1) v = IW'(int'($urandom_range(0, 600)) - 300);
    return v;
  endfunction

  // One clock cycle: record accepts and check any result leaving on this edge, then step to the next negedge.
  task automatic cycle();
    logic [IDW+OW-1:0] e;
    int                a;
    #1;
    granted = 1'b0;
    if (rst_n) begin
      ready_seen = ready_seen | req_ready;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({IDW'(i), model(src_d[i], int'(cfg_shift))});
          acc_q.push_back(cyc);
          granted    = 1'b1;
          last_grant = i;
        end
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
        check("out_id", 32'(out_id), 32'(e[IDW+OW-1:OW]));
        check("out_data", 32'(out_data), 32'(e[OW-1:0]));
        if (chk_lat) check("latency", cyc - a, 2);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // A new random word for a source that has just been accepted.
  task automatic refresh();
    if (granted) src_d[last_grant] = rnd_word();
  endtask

  task automatic send_single(input int x, input int s, input logic [OW-1:0] exp);
    src_d[0]  = IW'(x);
    cfg_shift = SW'(s);
    req_valid = 4'b0001;
    cycle();
    check("single_acc", 32'(granted), 1);
    req_valid = '0;
    check("single_lat1_valid", 32'(out_valid), 0);
    cycle();
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 32'(exp));
    check("single_id", 32'(out_id), 0);
    cycle();
  endtask

  initial begin
    int stall_guard;
    int ord[4];
    rst_n      = 1'b0;
    req_valid  = '0;
    cfg_shift  = '0;
    out_ready  = 1'b1;
    ready_seen = '0;
    for (int i = 0; i < NR; i++) src_d[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_id", 32'(out_id), 0);
    rst_n = 1'b1;
    cycle();

    // All four sources valid: grants go 0,1,2,3,... with no gaps in the output.
    for (int i = 0; i < NR; i++) src_d[i] = rnd_word();
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      cfg_shift = SW'($urandom_range(0, 31));
      cycle();
      check("rr_granted", 32'(granted), 1);
      check("rr_order", last_grant, k % 4);
      if (k >= 1) check("rr_no_gap", 32'(out_valid), 1);
      refresh();
    end
    req_valid = '0;
    repeat (3) cycle();

    // Move the pointer to 2 by accepting source 1. Then sources 1 and 3 alternate, starting with 3.
    req_valid = 4'b0010;
    cycle();
    check("ptr_setup", last_grant, 1);
    refresh();
    ord = '{3, 1, 3, 1};
    ready_seen = '0;
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cfg_shift = SW'($urandom_range(0, 8));
      cycle();
      check("sparse_order", last_grant, ord[k]);
      refresh();
    end
    check("sparse_ready_0_2", 32'(ready_seen & 4'b0101), 0);
    req_valid = '0;
    repeat (3) cycle();

    // Arithmetic corners on source 0.
    send_single(300, 0, 8'h7F);
    send_single(-300, 0, 8'h80);
    send_single(248, 4, 8'h10);
    send_single(-20, 3, 8'hFE);
    send_single(-24, 3, 8'hFD);
    send_single(-1, 31, 8'hFF);
    send_single(-3, 1, 8'hFF);
    send_single(3, 1, 8'h02);
    send_single(-1048576, 21, 8'hFF);
    send_single(1048575, 21, 8'h00);
    send_single(1048575, 20, 8'h01);
    send_single(-256, 1, 8'h80);
    send_single(-257, 1, 8'h80);
    send_single(255, 1, 8'h7F);

    // Backpressure with a full pipeline: the output holds and no beat is accepted.
    chk_lat = 1'b0;
    for (int i = 0; i < NR; i++) src_d[i] = rnd_word();
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      cfg_shift = SW'($urandom_range(0, 12));
      cycle();
      refresh();
    end
    out_ready  = 1'b0;
    hold_d     = out_data;
    hold_id    = out_id;
    ready_seen = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data_stable", 32'(out_data), 32'(hold_d));
      check("bp_id_stable", 32'(out_id), 32'(hold_id));
    end
    check("bp_ready_low", 32'(ready_seen), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cfg_shift = SW'($urandom_range(0, 12));
      cycle();
      refresh();
    end
    req_valid = '0;
    repeat (4) cycle();
    chk_lat = 1'b1;

    // Reset with beats in flight: the outputs clear at once and the pointer returns to 0.
    src_d[2]  = rnd_word();
    req_valid = 4'b0100;
    cycle();
    refresh();
    cycle();
    refresh();
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_id", 32'(out_id), 0);
    req_valid = '0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    cycle();
    rst_n     = 1'b1;
    src_d[2]  = rnd_word();
    src_d[3]  = rnd_word();
    req_valid = 4'b1100;
    cycle();
    check("post_rst_grant", last_grant, 2);
    req_valid = 4'b1000;
    cycle();
    check("post_rst_grant2", last_grant, 3);
    req_valid = '0;

    // Drain with a cycle budget.
    stall_guard = 0;
    while (exp_q.size() > 0 && stall_guard < 50) begin
      cycle();
      stall_guard++;
    end
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
